// File: rtl/bcd_to_bin_if.sv
// Handshake and data bundle between a digit-entry front end and the BCD-to-binary converter.
// The front end drives start and the six BCD digits; the converter returns status and result.
interface bcd_to_bin_if;
    logic        start;
    logic [3:0]  unit;
    logic [3:0]  ten;
    logic [3:0]  hun;
    logic [3:0]  tho;
    logic [3:0]  t_tho;
    logic [3:0]  h_hun;
    logic        busy;
    logic        done;
    logic        err;
    logic [19:0] data;

    modport master (
        output start, unit, ten, hun, tho, t_tho, h_hun,
        input  busy, done, err, data
    );

    modport slave (
        input  start, unit, ten, hun, tho, t_tho, h_hun,
        output busy, done, err, data
    );
endinterface

// File: rtl/bcd_to_bin.sv
// Sequential six-digit BCD to 20-bit binary converter using reverse double-dabble.
// Each SHIFT cycle shifts right once and subtracts 3 from every BCD nibble that is >= 8.
module bcd_to_bin (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    bcd_to_bin_if.slave  bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [43:0] work_q, work_d;
    logic [19:0] data_q, data_d;
    logic        err_q, err_d;

    logic [43:0] shifted;
    logic [43:0] corrected;
    logic        any_bad;

    // Work register: bcd_part in [43:20] (h_hun at the top), bin_part in [19:0].
    always_comb begin
        shifted   = work_q >> 1;
        corrected = shifted;
        any_bad   = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (shifted[20+4*i +: 4] >= 4'd8) begin
                corrected[20+4*i +: 4] = shifted[20+4*i +: 4] - 4'd3;
            end
            if (work_q[20+4*i +: 4] > 4'd9) begin
                any_bad = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    work_d  = {bus.h_hun, bus.t_tho, bus.tho, bus.hun, bus.ten, bus.unit, 20'd0};
                    cnt_d   = 5'd0;
                    err_d   = 1'b0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (any_bad) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                work_d = corrected;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd19) begin
                    data_d  = shifted[19:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            work_q  <= 44'd0;
            data_q  <= 20'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Status outputs decode registered state only, so they drop with reset immediately.
    assign bus.busy = (state_q == CHECK) || (state_q == SHIFT);
    assign bus.done = (state_q == DONE);
    assign bus.err  = (state_q == DONE) && err_q;
    assign bus.data = data_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin: a vector table of conversions plus hand-written
// sequences for ignored restarts, asynchronous reset and back-to-back operation.
module tb_bcd_to_bin;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    bcd_to_bin_if bus ();

    bcd_to_bin dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] digits;
        logic [19:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_digits(input logic [23:0] d);
        bus.h_hun = d[23:20];
        bus.t_tho = d[19:16];
        bus.tho   = d[15:12];
        bus.hun   = d[11:8];
        bus.ten   = d[7:4];
        bus.unit  = d[3:0];
    endtask

    // Pulse start for one edge, then count cycles to done (cycle 1 = the one after the edge).
    task automatic run_conv(input vec_t v, input int idx);
        int n;
        int busy_cnt;
        @(negedge clk);
        set_digits(v.digits);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        set_digits(24'h777777);
        busy_cnt = 0;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.done) begin
                n = i;
                break;
            end
            if (bus.busy) busy_cnt++;
        end
        if (n == 0) n = 99;
        check($sformatf("v%0d latency", idx), n, v.exp_err ? 2 : 22);
        check($sformatf("v%0d busy_cycles", idx), busy_cnt, v.exp_err ? 1 : 21);
        check($sformatf("v%0d busy_at_done", idx), {31'd0, bus.busy}, 0);
        check($sformatf("v%0d err", idx), {31'd0, bus.err}, {31'd0, v.exp_err});
        check($sformatf("v%0d data", idx), {12'd0, bus.data}, {12'd0, v.exp_data});
        @(negedge clk);
        check($sformatf("v%0d done_pulse", idx), {31'd0, bus.done}, 0);
    endtask

    initial begin
        int done_cnt;
        int first_done;
        int last_done;
        int busy_seen;

        total = 0;
        bad   = 0;

        vecs[0] = '{24'h123456, 20'h1E240, 1'b0};
        vecs[1] = '{24'h000000, 20'h00000, 1'b0};
        vecs[2] = '{24'h999999, 20'hF423F, 1'b0};
        vecs[3] = '{24'h123456, 20'h1E240, 1'b0};
        vecs[4] = '{24'h1234A6, 20'h1E240, 1'b1};
        vecs[5] = '{24'h000001, 20'h00001, 1'b0};
        vecs[6] = '{24'h100000, 20'h186A0, 1'b0};
        vecs[7] = '{24'h065535, 20'h0FFFF, 1'b0};
        vecs[8] = '{24'hF00000, 20'h0FFFF, 1'b1};
        vecs[9] = '{24'h654321, 20'h9FBF1, 1'b0};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        set_digits(24'h000000);
        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, bus.busy}, 0);
        check("reset done", {31'd0, bus.done}, 0);
        check("reset err", {31'd0, bus.err}, 0);
        check("reset data", {12'd0, bus.data}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 10; k++) begin
            run_conv(vecs[k], k);
        end

        // Asynchronous reset in the middle of a 999999 conversion.
        @(negedge clk);
        set_digits(24'h999999);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async rst busy", {31'd0, bus.busy}, 0);
        check("async rst done", {31'd0, bus.done}, 0);
        check("async rst err", {31'd0, bus.err}, 0);
        check("async rst data", {12'd0, bus.data}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt  = 0;
        busy_seen = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
            if (bus.busy) busy_seen++;
        end
        check("post rst no done", done_cnt, 0);
        check("post rst no busy", busy_seen, 0);
        check("post rst data", {12'd0, bus.data}, 0);

        // Start 654321, then re-pulse start with other digits at cycles 5 and 15.
        @(negedge clk);
        set_digits(24'h654321);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        done_cnt   = 0;
        first_done = 0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done) begin
                done_cnt++;
                if (first_done == 0) first_done = i;
            end
            if (i == 5 || i == 15) begin
                set_digits(24'h111111);
                bus.start = 1'b1;
            end
        end
        check("restart done count", done_cnt, 1);
        check("restart done cycle", first_done, 22);
        check("restart data", {12'd0, bus.data}, {12'd0, 20'h9FBF1});

        // Start held high: a conversion every 23 cycles.
        @(negedge clk);
        set_digits(24'h000042);
        bus.start = 1'b1;
        @(posedge clk);
        done_cnt  = 0;
        last_done = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (bus.done) begin
                done_cnt++;
                check($sformatf("b2b data #%0d", done_cnt), {12'd0, bus.data},
                      {12'd0, 20'h0002A});
                check($sformatf("b2b cycle #%0d", done_cnt), i - last_done,
                      (last_done == 0) ? 22 : 23);
                last_done = i;
            end
        end
        bus.start = 1'b0;
        check("b2b done count", done_cnt, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
